// File: rtl/ps2_rx_fifo.sv
// PS/2 device receiver with first-word-fall-through scan-code FIFO.
// Raw ps2_clk/ps2_data are synchronised. The clock is glitch-filtered by a
// prescaled shift register. Frames are checked for odd parity and stop bit.
// Optional feature macro: PS2_INHIBIT_EN adds ps2_clk_oe, which holds the
// PS/2 clock low while the FIFO is full.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | latching the parity bit
// S_STOP   | checking the stop bit, then push / flag error

module ps2_rx_fifo #(
    parameter int CLK_DIV     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              read,
    input  logic              clr_err,
    output logic              scan_ready,
    output logic [7:0]        scan_code,
    output logic [ADDR_W:0]   fifo_count,
    output logic              parity_err,
    output logic              frame_err,
`ifdef PS2_INHIBIT_EN
    output logic              ps2_clk_oe,
`endif
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              state;
    logic                clk_s1, clk_s2, data_s1, data_s2;
    logic [PW-1:0]       prsc;
    logic                smp_stb;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                filt_clk;
    logic                fall_stb;
    logic [TW-1:0]       to_cnt;
    logic                timeout;
    logic [2:0]          bit_cnt;
    logic [7:0]          shreg;
    logic                par_bit;
    logic                par_ok, stop_stb, push, pop, full, wr_en;
    logic                par_set, frm_set, ovf_set;
    logic [ADDR_W:0]     wr_ptr, rd_ptr;
    logic [7:0]          mem [DEPTH];

    assign smp_stb  = (prsc == PW'(CLK_DIV - 1));
    // Strobe in the one cycle where the filter has seen all-low but filt_clk is still high.
    assign fall_stb = filt_clk && (filt_sr == '0);
    assign timeout  = (state != S_IDLE) && !fall_stb && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign par_ok   = ^{shreg, par_bit};
    assign stop_stb = fall_stb && (state == S_STOP);
    assign push     = stop_stb && data_s2 && par_ok;
    assign par_set  = stop_stb && data_s2 && !par_ok;
    assign frm_set  = (stop_stb && !data_s2) || timeout;

    assign fifo_count = wr_ptr - rd_ptr;
    assign scan_ready = (fifo_count != '0);
    assign full       = (fifo_count == (ADDR_W + 1)'(DEPTH));
    assign pop        = read && scan_ready;
    assign wr_en      = push && (!full || pop);
    assign ovf_set    = push && full && !pop;
    assign scan_code  = scan_ready ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;

    // Two-flop synchronisers for the asynchronous PS/2 lines (idle high).
    always_ff @(posedge clk_100) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Prescaler producing the filter sample strobe.
    always_ff @(posedge clk_100) begin
        if (reset)        prsc <= '0;
        else if (smp_stb) prsc <= '0;
        else              prsc <= prsc + PW'(1);
    end

    // Majority-free glitch filter: output changes only after FILTER_LEN equal samples.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            filt_sr  <= '1;
            filt_clk <= 1'b1;
        end else begin
            if (smp_stb) filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr)             filt_clk <= 1'b1;
            else if (filt_sr == '0)   filt_clk <= 1'b0;
        end
    end

    // Frame FSM with inter-edge timeout.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state == S_IDLE || fall_stb || timeout) to_cnt <= '0;
            else                                        to_cnt <= to_cnt + TW'(1);

            if (timeout) begin
                state <= S_IDLE;
            end else if (fall_stb) begin
                case (state)
                    S_IDLE: begin
                        if (!data_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= data_s2;
                        state   <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky error flags; a set in the same cycle beats clr_err.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (par_set)      parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
            if (frm_set)      frame_err  <= 1'b1;
            else if (clr_err) frame_err  <= 1'b0;
            if (ovf_set)      overflow   <= 1'b1;
            else if (clr_err) overflow   <= 1'b0;
        end
    end

    // FIFO pointers; widths of ADDR_W+1 let full and empty be told apart.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
        end
    end

    // FIFO storage, written with the byte completed by the stop bit.
    always_ff @(posedge clk_100) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= shreg;
    end

`ifdef PS2_INHIBIT_EN
    // Hold the PS/2 clock low once full between frames; release with two free slots.
    always_ff @(posedge clk_100) begin
        if (reset)
            ps2_clk_oe <= 1'b0;
        else if (full && state == S_IDLE)
            ps2_clk_oe <= 1'b1;
        else if (fifo_count <= (ADDR_W + 1)'(DEPTH - 2))
            ps2_clk_oe <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo (small FIFO, short timeout, fast PS/2 clock).
module tb_ps2_rx_fifo;

    localparam int CLK_DIV = 4;
    localparam int FILT    = 8;
    localparam int AW      = 2;
    localparam int TO      = 1000;
    localparam int H       = 60;
    localparam int DEPTH   = 4;

    logic clk_100 = 1'b0;
    logic reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, read = 1'b0, clr_err = 1'b0;
    logic scan_ready, parity_err, frame_err, overflow;
    logic [7:0] scan_code;
    logic [AW:0] fifo_count;
`ifdef PS2_INHIBIT_EN
    logic ps2_clk_oe;
`endif

    ps2_rx_fifo #(.CLK_DIV(CLK_DIV), .FILTER_LEN(FILT), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
`ifdef PS2_INHIBIT_EN
        .ps2_clk_oe(ps2_clk_oe),
`endif
        .clk_100(clk_100), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .read(read), .clr_err(clr_err), .scan_ready(scan_ready), .scan_code(scan_code),
        .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int t_last = 0;
    bit glitch = 1'b0;

    // Reference model: byte queue plus sticky flags.
    logic [7:0] q[$];
    bit m_par, m_frm, m_ovf;

    logic [14:0] obs;
    assign obs = {scan_ready, scan_code, fifo_count, parity_err, frame_err, overflow};

    function automatic logic [14:0] exp_vec();
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        return {q.size() > 0, head, 3'(q.size()), m_par, m_frm, m_ovf};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic align();
        while (cyc % CLK_DIV != 0) wait_cyc(1);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        t_last = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
        if (glitch) begin
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(H - 33);
        end else begin
            wait_cyc(H - 10);
        end
    endtask

    task automatic send_head(input logic [7:0] b, input bit pb);
        align();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ pb);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pb, input bit sb);
        send_head(b, pb);
        send_bit(~sb);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit pb, input bit sb);
        if (sb)                  m_frm = 1'b1;
        else if (pb)             m_par = 1'b1;
        else if (q.size() == DEPTH) m_ovf = 1'b1;
        else                     q.push_back(b);
    endtask

    task automatic do_read();
        read = 1'b1;
        wait_cyc(1);
        read = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        m_par = 0; m_frm = 0; m_ovf = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        q.delete();
        m_par = 0; m_frm = 0; m_ovf = 0;
        wait_cyc(2);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs !== 15'h0) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs, 15'h0);
        end
`ifdef PS2_INHIBIT_EN
        total++;
        if (ps2_clk_oe !== 1'b0) begin
            bad++; $display("FAIL reset_oe: got %b want 0", ps2_clk_oe);
        end
`endif
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 0, 0); model_frame(8'h1C, 0, 0);
        total++;
        if (obs !== {1'b1, 8'h1C, 3'd1, 3'b000}) begin
            bad++; $display("FAIL basic_1c: got %h want %h", obs, {1'b1, 8'h1C, 3'd1, 3'b000});
        end
        do_read();
        total++;
        if (obs !== 15'h0) begin
            bad++; $display("FAIL basic_pop: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1, 0); model_frame(8'h1C, 1, 0);
        total++;
        if (obs !== {1'b0, 8'h00, 3'd0, 3'b100}) begin
            bad++; $display("FAIL parity_err: got %h want %h", obs, {1'b0, 8'h00, 3'd0, 3'b100});
        end
        do_clr();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL parity_clr: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            int kind, nr;
            b = 8'($urandom);
            kind = $urandom_range(0, 6);
            send_frame(b, kind == 0, kind == 1);
            model_frame(b, kind == 0, kind == 1);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random_frame%0d: got %h want %h", n, obs, exp_vec());
            end
            nr = $urandom_range(0, 2);
            for (int r = 0; r < nr; r++) do_read();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random_read%0d: got %h want %h", n, obs, exp_vec());
            end
            if ((n % 4) == 3) do_clr();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            want = 8'(i * 8'h11);
            send_frame(want, 0, 0); model_frame(want, 0, 0);
`ifdef PS2_INHIBIT_EN
            if (i == 4) begin
                wait_cyc(3);
                total++;
                if (ps2_clk_oe !== 1'b1) begin
                    bad++; $display("FAIL oe_full: got %b want 1", ps2_clk_oe);
                end
            end
`endif
        end
        total++;
        if (obs !== {1'b1, 8'h11, 3'd4, 3'b001}) begin
            bad++; $display("FAIL ovf_state: got %h want %h", obs, {1'b1, 8'h11, 3'd4, 3'b001});
        end
        for (int i = 1; i <= 4; i++) begin
            want = 8'(i * 8'h11);
            total++;
            if (scan_code !== want || scan_ready !== 1'b1) begin
                bad++; $display("FAIL ovf_read%0d: got %h/%b want %h/1", i, scan_code, scan_ready, want);
            end
            do_read();
`ifdef PS2_INHIBIT_EN
            wait_cyc(2);
            if (i == 1 || i == 2) begin
                total++;
                if (ps2_clk_oe !== (i == 1)) begin
                    bad++; $display("FAIL oe_after_read%0d: got %b want %b", i, ps2_clk_oe, i == 1);
                end
            end
`endif
        end
        total++;
        if (obs !== exp_vec() || scan_ready !== 1'b0) begin
            bad++; $display("FAIL ovf_drain: got %h want %h", obs, exp_vec());
        end
        do_clr();
    endtask

    task automatic test_timeout();
        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        while (cyc < t_last + TO) wait_cyc(1);
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL timeout_early: got %b want 0", frame_err);
        end
        while (cyc < t_last + TO + FILT * CLK_DIV + CLK_DIV + 12) wait_cyc(1);
        m_frm = 1'b1;
        total++;
        if (obs !== exp_vec() || frame_err !== 1'b1) begin
            bad++; $display("FAIL timeout_set: got %h want %h", obs, exp_vec());
        end
        do_clr();
        send_frame(8'hF0, 0, 0); model_frame(8'hF0, 0, 0);
        total++;
        if (obs !== {1'b1, 8'hF0, 3'd1, 3'b000}) begin
            bad++; $display("FAIL timeout_next: got %h want %h", obs, {1'b1, 8'hF0, 3'd1, 3'b000});
        end
        do_read();
    endtask

    task automatic test_glitch();
        glitch = 1'b1;
        send_frame(8'h5A, 0, 0); model_frame(8'h5A, 0, 0);
        glitch = 1'b0;
        total++;
        if (obs !== {1'b1, 8'h5A, 3'd1, 3'b000}) begin
            bad++; $display("FAIL glitch_5a: got %h want %h", obs, {1'b1, 8'h5A, 3'd1, 3'b000});
        end
        align();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        do_reset();
        send_frame(8'h5A, 0, 0); model_frame(8'h5A, 0, 0);
        total++;
        if (obs !== {1'b1, 8'h5A, 3'd1, 3'b000}) begin
            bad++; $display("FAIL reset_midframe: got %h want %h", obs, {1'b1, 8'h5A, 3'd1, 3'b000});
        end
        do_read();
    endtask

    task automatic test_back_to_back();
        logic [AW:0] prev;
        int t0, lat;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'(8'hA0 + i), 0, 0); model_frame(8'(8'hA0 + i), 0, 0);
        end
        // Measure stop-edge-to-push latency on the 4th byte.
        send_head(8'hA4, 0);
        ps2_data = 1'b1;
        wait_cyc(10);
        ps2_clk = 1'b0;
        t0 = cyc;
        prev = fifo_count;
        lat = -1;
        for (int i = 0; i < H; i++) begin
            wait_cyc(1);
            if (lat < 0 && fifo_count !== prev) lat = cyc - t0;
        end
        ps2_clk = 1'b1;
        wait_cyc(H);
        model_frame(8'hA4, 0, 0);
        total++;
        if (lat < 0 || obs !== exp_vec()) begin
            bad++; $display("FAIL b2b_fill: got %h lat %0d want %h", obs, lat, exp_vec());
        end
        // 5th byte arrives while full; pop in exactly the push cycle.
        send_head(8'hA5, 0);
        ps2_data = 1'b1;
        wait_cyc(10);
        ps2_clk = 1'b0;
        t0 = cyc;
        for (int i = 0; i < H; i++) begin
            read = (lat > 0 && cyc == t0 + lat - 1);
            wait_cyc(1);
        end
        read = 1'b0;
        ps2_clk = 1'b1;
        wait_cyc(H);
        void'(q.pop_front());
        q.push_back(8'hA5);
        total++;
        if (obs !== {1'b1, 8'hA2, 3'd4, 3'b000}) begin
            bad++; $display("FAIL b2b_full_pushpop: got %h want %h", obs, {1'b1, 8'hA2, 3'd4, 3'b000});
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL b2b_drain%0d: got %h want %h", i, obs, exp_vec());
            end
            do_read();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_random();
        test_overflow();
        test_timeout();
        test_glitch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
